serial_word_feeder: RTL
=======================

# serial_word_feeder

Upstream driver for the N-bit bi-directional shift register. It accepts parallel words over a valid/ready handshake and serializes each word bit by bit onto the shift register's `en`/`dir`/`d` inputs. It selects bit order per word to match the shift direction, and supports stalling. The shift register's parallel `out` becomes valid once a word's last bit has been shifted in.

## Interface
- `MSB`, 16, word width in bits; must equal the downstream shift register's `MSB`; minimum 2.
- `clk`  input  1  rising-edge clock shared with the shift register.
- `rst`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  upstream word available.
- `in_ready`  output  1  feeder can accept a word this cycle.
- `in_data`  input  MSB  word to serialize.
- `in_dir`  input  1  shift direction for this word; forwarded to `dir`.
- `stall`  input  1  pause serialization. While high, `en`=0 and the bit counter holds.
- `en`  output  1  shift enable to the shift register.
- `dir`  output  1  shift direction to the shift register.
- `d`  output  1  serial data bit to the shift register.
- `busy`  output  1  word captured and not yet fully sent.
- `done`  output  1  one-cycle pulse after the final bit of a word is shifted.

## Operation
- All outputs are registered.
- Reset values: `in_ready`=0, `en`=0, `dir`=0, `d`=0, `busy`=0, `done`=0. The state machine resets to IDLE and the bit counter to 0.
- `in_ready` rises on the first `clk` edge after `rst` deasserts.
- The bit counter is $clog2(MSB+1) bits wide.
- IDLE
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture `in_data` into the shadow register and `in_dir` into the direction register, clear the counter, and go to SHIFT.
  - `in_ready` drops on the same edge.
- SHIFT
  - When `stall`=0, each cycle: `en`=1, `dir`=captured direction, and `d` = next bit.
  - `dir`=0 sends MSB-first (bit MSB-1 down to 0). `dir`=1 sends LSB-first (bit 0 up to MSB-1).
  - The counter increments per sent bit.
  - After bit MSB has been sent: go to PARITY if enabled, otherwise to DONE.
- PARITY (macro only): one cycle with `en`=1 and `d` = even parity of the captured word, subject to `stall`. Then go to DONE.
- DONE: `en`=0, `done`=1 for exactly one cycle, then go to IDLE.
- `busy` is 1 in SHIFT, PARITY and DONE.
- `in_valid` is ignored outside IDLE. `in_data` and `in_dir` are sampled only at the handshake.
- `stall` in IDLE or DONE has no effect. A `stall` asserted on the cycle of the last bit delays that bit and the DONE transition.

## Timing
- Handshake at edge k → first bit (`en`=1) is visible in the cycle after edge k.
- Without stall, a word occupies MSB cycles of `en`=1, then 1 DONE cycle, then 1 IDLE cycle. Back-to-back throughput is one word per MSB+2 cycles (MSB+3 with parity).
- `dir` is stable for the whole word, including the parity bit.
- Reset asserted mid-word:
  - Outputs go to their reset values immediately, asynchronously; the partial word is discarded and no `done` is issued.
  - After release, the feeder is ready one edge later.

## Configuration
- `SERIAL_WORD_FEEDER_PARITY_EN`
  - Defined: the PARITY state is compiled in, and each word is followed by one even-parity bit on `d` with `en`=1.
  - Undefined: the PARITY state and parity logic are absent, and exactly MSB bits are sent per word.

## Structure
- Shared package `shift_pkg`:
  - state encoding constants: IDLE, SHIFT, PARITY, DONE;
  - direction constants: `DIR_MSB_FIRST`=0, `DIR_LSB_FIRST`=1;
  - the `even_parity` function.
- No sub-module. The FSM, counter and shadow register live in one module, which the bench instantiates directly in front of `ShiftRegister`.

## Test plan
- Reset release: hold `rst`=0 for 20 ns, then release → all outputs 0 during reset; `in_ready`=1 one edge after release.
- MSB=16, `in_data`=16'hA5C3, `in_dir`=0, no stall → `d` sequence is 1010010111000011 over 16 consecutive `en` cycles; shift register `out`=16'hA5C3; `done` pulses once.
- Same word with `in_dir`=1 → bits sent LSB-first (1100001110100101); `dir`=1 throughout; shift register `out`=16'hA5C3.
- Assert `stall` for 3 cycles mid-word (after bit 5) → `en`=0 for exactly those 3 cycles; total `en` count is still 16; `done` is delayed by 3 cycles.
- Two words presented with `in_valid` held high (16'hFFFF then 16'h0001) → second handshake occurs 18 cycles after the first; no bit loss.
- Reset asserted after 7 bits → `en`, `busy` and `d` drop immediately; no `done`; the next word sends a full 16 bits.
- Build with `SERIAL_WORD_FEEDER_PARITY_EN` and send 16'h0007 → 17 `en` cycles; final `d`=1 (odd number of ones in the word, so the even-parity bit is 1).

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and helpers for the serial word feeder.
// Parity support is compiled in by SERIAL_WORD_FEEDER_PARITY_EN.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    DONE
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  function automatic logic even_parity(
    input logic [63:0] w
  );
    return ^w;
  endfunction

endpackage

// File: rtl/serial_word_feeder.sv
// Serializes handshaken words onto a shift register en/dir/d port.
// Define SERIAL_WORD_FEEDER_PARITY_EN to append an even-parity bit.
module serial_word_feeder
  import shift_pkg::*;
#(
  parameter int MSB = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MSB-1:0] in_data,
  input  logic           in_dir,
  input  logic           stall,
  output logic           en,
  output logic           dir,
  output logic           d,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(MSB + 1);

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [MSB-1:0] word, word_n, word_sh;
  logic           dir_n, en_n, d_n;
  logic           rdy_n, busy_n, done_n;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
  logic           par, par_n;
`endif

  // cnt counts bits already clocked into the shift register;
  // word is shifted so the next bit is always at the send end.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word;
    dir_n   = dir;
    en_n    = 1'b0;
    d_n     = 1'b0;
    rdy_n   = 1'b0;
    busy_n  = 1'b1;
    done_n  = 1'b0;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    par_n   = par;
`endif
    word_sh = (dir == DIR_LSB_FIRST) ? (word >> 1) : (word << 1);
    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        rdy_n  = 1'b1;
        if (in_valid && in_ready) begin
          state_n = SHIFT;
          cnt_n   = '0;
          word_n  = in_data;
          dir_n   = in_dir;
          en_n    = 1'b1;
          d_n     = in_dir ? in_data[0] : in_data[MSB-1];
          rdy_n   = 1'b0;
          busy_n  = 1'b1;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
          par_n   = even_parity(64'(in_data));
`endif
        end
      end
      SHIFT: begin
        if (en) begin
          cnt_n  = cnt + CW'(1);
          word_n = word_sh;
        end
        if (cnt_n == CW'(MSB)) begin
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
          state_n = PARITY;
          en_n    = !stall;
          d_n     = par;
`else
          state_n = DONE;
          done_n  = 1'b1;
`endif
        end else begin
          en_n = !stall;
          d_n  = (dir == DIR_LSB_FIRST) ? word_n[0]
                                         : word_n[MSB-1];
        end
      end
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
      PARITY: begin
        if (en) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          en_n = !stall;
          d_n  = par;
        end
      end
`endif
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        rdy_n   = 1'b1;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      word     <= '0;
      dir      <= 1'b0;
      en       <= 1'b0;
      d        <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      word     <= word_n;
      dir      <= dir_n;
      en       <= en_n;
      d        <= d_n;
      in_ready <= rdy_n;
      busy     <= busy_n;
      done     <= done_n;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
      par      <= par_n;
`endif
    end
  end

endmodule
